// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single memory port between icache refill and dcache refill/write-back.
// Define CACHE_ARB_RR_EN for round-robin on conflicts; otherwise the dcache always wins.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ok,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_wen,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_ok,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ok
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic                grant;  // 1 selects the dcache

`ifdef CACHE_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (i_req && d_req) grant = ~last_grant_q;
    else                grant = d_req;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b0;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign grant = d_req;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    resp_d  = resp_q;
`ifdef CACHE_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant;
          state_d = BUSY;
`ifdef CACHE_ARB_RR_EN
          last_grant_d = grant;
`endif
          if (grant) begin
            wen_d   = d_wen;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
          end else begin
            wen_d   = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ok) begin
          resp_d  = wen_q ? '0 : mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      resp_q  <= resp_d;
    end
  end

  // Request buffer drives the memory fields directly, so they stay stable while BUSY.
  assign mem_req   = (state_q == BUSY);
  assign mem_wen   = wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  assign i_ok    = (state_q == RESP) && !owner_q;
  assign d_ok    = (state_q == RESP) && owner_q;
  assign i_rdata = i_ok ? resp_q : '0;
  assign d_rdata = d_ok ? resp_q : '0;

endmodule
